// File: rtl/swap_race_monitor_if.sv
// Signal bundle between the swap/collapse monitor and whatever drives the exercise pairs.
// start/stop are single-cycle pulses sampled on rising clk; outputs are registered or state-decoded.
interface swap_race_monitor_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             a_blk;
  logic             b_blk;
  logic             a_nb;
  logic             b_nb;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] cycles;
  logic [CNT_W-1:0] nb_fail_cnt;
  logic [CNT_W-1:0] blk_collapse_cnt;
  logic [CNT_W-1:0] first_fail_cyc;
  logic [1:0]       state_dbg;

  modport master (
    output start, stop, a_blk, b_blk, a_nb, b_nb,
    input  busy, done, err, cycles, nb_fail_cnt, blk_collapse_cnt, first_fail_cyc, state_dbg
  );

  modport slave (
    input  start, stop, a_blk, b_blk, a_nb, b_nb,
    output busy, done, err, cycles, nb_fail_cnt, blk_collapse_cnt, first_fail_cyc, state_dbg
  );
endinterface

// File: rtl/swap_race_monitor.sv
// Monitors a nonblocking register pair for a true swap and a blocking pair for collapse,
// accumulating saturating pass/fail counters over a start..stop run.
module swap_race_monitor #(
  parameter int CNT_W  = 16,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  swap_race_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ALL_ONES    = {CNT_W{1'b1}};
  localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE - 1);

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_settle;
  logic [3:0]       w_settle_nxt;
  logic             w_clear;
  logic             w_check;
  logic             r_pa_nb;
  logic             r_pb_nb;
  logic             r_err;
  logic [CNT_W-1:0] r_cycles;
  logic [CNT_W-1:0] r_nb_fail;
  logic [CNT_W-1:0] r_collapse;
  logic [CNT_W-1:0] r_first;
  logic             w_nb_pass;
  logic             w_blk_eq;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == ALL_ONES) ? v : v + 1'b1;
  endfunction

  // A true swap means each output now holds what the other held one edge ago.
  assign w_nb_pass = (bus.a_nb == r_pb_nb) && (bus.b_nb == r_pa_nb);
  assign w_blk_eq  = (bus.a_blk == bus.b_blk);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_settle <= '0;
    end else begin
      r_state  <= w_next;
      r_settle <= w_settle_nxt;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_settle_nxt = r_settle;
    w_clear      = 1'b0;
    w_check      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next       = S_SETTLE;
          w_clear      = 1'b1;
          w_settle_nxt = SETTLE_INIT;
        end
      end
      S_SETTLE: begin
        if (r_settle == 4'd0) w_next = S_CHECK;
        else                  w_settle_nxt = r_settle - 4'd1;
      end
      S_CHECK: begin
        w_check = 1'b1;
        if (bus.stop) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Previous nb samples track the pair continuously so the first check has a valid history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pa_nb <= 1'b0;
      r_pb_nb <= 1'b0;
    end else begin
      r_pa_nb <= bus.a_nb;
      r_pb_nb <= bus.b_nb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_cycles   <= '0;
      r_nb_fail  <= '0;
      r_collapse <= '0;
      r_first    <= ALL_ONES;
    end else if (w_clear) begin
      r_err      <= 1'b0;
      r_cycles   <= '0;
      r_nb_fail  <= '0;
      r_collapse <= '0;
      r_first    <= ALL_ONES;
    end else if (w_check) begin
      r_cycles <= sat_inc(r_cycles);
      if (!w_nb_pass) begin
        r_nb_fail <= sat_inc(r_nb_fail);
        r_err     <= 1'b1;
        if (!r_err) r_first <= r_cycles;
      end
      if (w_blk_eq) r_collapse <= sat_inc(r_collapse);
    end
  end

  assign bus.busy             = (r_state == S_SETTLE) || (r_state == S_CHECK);
  assign bus.done             = (r_state == S_DONE);
  assign bus.err              = r_err;
  assign bus.cycles           = r_cycles;
  assign bus.nb_fail_cnt      = r_nb_fail;
  assign bus.blk_collapse_cnt = r_collapse;
  assign bus.first_fail_cyc   = r_first;
  assign bus.state_dbg        = r_state;

endmodule

// File: tb/tb_swap_race_monitor.sv
// Bench for swap_race_monitor: two instances (16-bit and 4-bit counters) share one stimulus
// stream and are compared every cycle against a run-level model plus literal end-of-run values.
module tb_swap_race_monitor;

  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic t_start = 1'b0, t_stop = 1'b0;
  logic t_a_blk = 1'b0, t_b_blk = 1'b0, t_a_nb = 1'b0, t_b_nb = 1'b0;
  logic ph = 1'b0;
  logic blk_a_v = 1'b1, blk_b_v = 1'b1;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  swap_race_monitor_if #(.CNT_W(16)) bus16 ();
  swap_race_monitor_if #(.CNT_W(4))  bus4 ();

  assign bus16.start = t_start;  assign bus4.start = t_start;
  assign bus16.stop  = t_stop;   assign bus4.stop  = t_stop;
  assign bus16.a_blk = t_a_blk;  assign bus4.a_blk = t_a_blk;
  assign bus16.b_blk = t_b_blk;  assign bus4.b_blk = t_b_blk;
  assign bus16.a_nb  = t_a_nb;   assign bus4.a_nb  = t_a_nb;
  assign bus16.b_nb  = t_b_nb;   assign bus4.b_nb  = t_b_nb;

  swap_race_monitor #(.CNT_W(16), .SETTLE(SETTLE)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  swap_race_monitor #(.CNT_W(4),  .SETTLE(SETTLE)) dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A run is "open" from the accepted start edge; edges at or beyond start+SETTLE+1 are checks.
  int  m_max[2] = '{65535, 15};
  int  m_cyc[2] = '{0, 0};
  int  m_fail[2] = '{0, 0};
  int  m_coll[2] = '{0, 0};
  int  m_first[2] = '{65535, 15};
  bit  m_err[2] = '{1'b0, 1'b0};
  bit  m_in_run = 1'b0;
  bit  m_done = 1'b0;
  int  m_edge = 0;
  int  m_run_start = 0;
  bit  m_pa = 1'b0, m_pb = 1'b0;

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  always begin
    bit was_done;
    bit pass;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_in_run = 1'b0;
      m_done   = 1'b0;
      m_pa     = 1'b0;
      m_pb     = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_cyc[i] = 0; m_fail[i] = 0; m_coll[i] = 0; m_err[i] = 1'b0; m_first[i] = m_max[i];
      end
    end else begin
      m_edge++;
      was_done = m_done;
      m_done   = 1'b0;
      pass     = (t_a_nb == m_pb) && (t_b_nb == m_pa);
      if (m_in_run) begin
        if (m_edge >= m_run_start + SETTLE + 1) begin
          for (int i = 0; i < 2; i++) begin
            if (!pass) begin
              if (!m_err[i]) m_first[i] = m_cyc[i];
              m_err[i]  = 1'b1;
              m_fail[i] = sat(m_fail[i], m_max[i]);
            end
            if (t_a_blk == t_b_blk) m_coll[i] = sat(m_coll[i], m_max[i]);
            m_cyc[i] = sat(m_cyc[i], m_max[i]);
          end
          if (t_stop) begin
            m_in_run = 1'b0;
            m_done   = 1'b1;
          end
        end
      end else if (!was_done && t_start) begin
        m_in_run    = 1'b1;
        m_run_start = m_edge;
        for (int i = 0; i < 2; i++) begin
          m_cyc[i] = 0; m_fail[i] = 0; m_coll[i] = 0; m_err[i] = 1'b0; m_first[i] = m_max[i];
        end
      end
      m_pa = t_a_nb;
      m_pb = t_b_nb;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clk);
    #2;
    if (bus16.done) done_seen++;
    chk("busy16",  int'(bus16.busy), int'(m_in_run));
    chk("done16",  int'(bus16.done), int'(m_done));
    chk("err16",   int'(bus16.err),  int'(m_err[0]));
    chk("cyc16",   int'(bus16.cycles), m_cyc[0]);
    chk("fail16",  int'(bus16.nb_fail_cnt), m_fail[0]);
    chk("coll16",  int'(bus16.blk_collapse_cnt), m_coll[0]);
    chk("first16", int'(bus16.first_fail_cyc), m_first[0]);
    chk("busy4",   int'(bus4.busy), int'(m_in_run));
    chk("done4",   int'(bus4.done), int'(m_done));
    chk("err4",    int'(bus4.err),  int'(m_err[1]));
    chk("cyc4",    int'(bus4.cycles), m_cyc[1]);
    chk("fail4",   int'(bus4.nb_fail_cnt), m_fail[1]);
    chk("coll4",   int'(bus4.blk_collapse_cnt), m_coll[1]);
    chk("first4",  int'(bus4.first_fail_cyc), m_first[1]);
  end

  // ---------------- driver ----------------
  // One call = one rising edge; returns just after that edge so results are readable.
  task automatic cyc(input bit st, input bit sp, input bit force_nb);
    @(negedge clk);
    ph      = ~ph;
    t_start = st;
    t_stop  = sp;
    t_a_nb  = force_nb ? 1'b1 : ph;
    t_b_nb  = force_nb ? 1'b0 : ~ph;
    t_a_blk = blk_a_v;
    t_b_blk = blk_b_v;
    @(posedge clk);
    #3;
  endtask

  task automatic std_run(input int n_checks, input int fault_idx);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n_checks; i++)
      cyc(1'b0, (i == n_checks - 1), (i == fault_idx));
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_busy",  int'(bus16.busy), 0);
    chk("rst_done",  int'(bus16.done), 0);
    chk("rst_err",   int'(bus16.err), 0);
    chk("rst_cyc",   int'(bus16.cycles), 0);
    chk("rst_fail",  int'(bus16.nb_fail_cnt), 0);
    chk("rst_coll",  int'(bus16.blk_collapse_cnt), 0);
    chk("rst_first", int'(bus16.first_fail_cyc), 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;

    // Ideal pairs: nb swaps every cycle, blk pair collapsed.
    blk_a_v = 1'b1; blk_b_v = 1'b1; ph = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    d0 = done_seen;
    std_run(10, -1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("ideal_cycles", int'(bus16.cycles), 10);
    chk("ideal_fail",   int'(bus16.nb_fail_cnt), 0);
    chk("ideal_err",    int'(bus16.err), 0);
    chk("ideal_coll",   int'(bus16.blk_collapse_cnt), 10);
    chk("ideal_first",  int'(bus16.first_fail_cyc), 16'hFFFF);
    chk("ideal_done_pulses", done_seen - d0, 1);
    chk("model_ideal_cycles", m_cyc[0], 10);

    // Injected fault: nb pair stuck at (1,0) for check index 4.
    ph = 1'b0;
    std_run(10, 4);
    cyc(1'b0, 1'b0, 1'b0);
    chk("fault_err",   int'(bus16.err), 1);
    chk("fault_fail",  int'(bus16.nb_fail_cnt), 2);
    chk("fault_first", int'(bus16.first_fail_cyc), 4);
    chk("model_fault_fail", m_fail[0], 2);

    // start+stop together in idle, stop during settle, start during check.
    cyc(1'b1, 1'b1, 1'b0);
    chk("startstop_busy", int'(bus16.busy), 1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("settle_stop_busy", int'(bus16.busy), 1);
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc((i == 3), (i == 7), 1'b0);
    chk("ignore_cycles", int'(bus16.cycles), 8);
    chk("ignore_coll",   int'(bus16.blk_collapse_cnt), 8);
    cyc(1'b0, 1'b0, 1'b0);

    // Saturation: constant fault for 20 checks.
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b0, (i == 19), 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("sat4_cycles", int'(bus4.cycles), 15);
    chk("sat4_fail",   int'(bus4.nb_fail_cnt), 15);
    chk("sat4_first",  int'(bus4.first_fail_cyc), 0);
    chk("sat16_cycles", int'(bus16.cycles), 20);
    chk("sat16_fail",   int'(bus16.nb_fail_cnt), 20);

    // Reset mid-run at check 5.
    d0 = done_seen;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, (i == 2));
    @(negedge clk);
    rst_n = 1'b0;
    t_start = 1'b0; t_stop = 1'b0;
    #1;
    chk("mrst_busy",  int'(bus16.busy), 0);
    chk("mrst_err",   int'(bus16.err), 0);
    chk("mrst_cyc",   int'(bus16.cycles), 0);
    chk("mrst_first", int'(bus16.first_fail_cyc), 16'hFFFF);
    repeat (2) @(posedge clk);
    #3;
    chk("mrst_no_done", done_seen - d0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ph = 1'b0;
    std_run(6, -1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("post_rst_cycles", int'(bus16.cycles), 6);
    chk("post_rst_done",   done_seen - d0, 1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      blk_a_v = 1'($urandom_range(0, 1));
      blk_b_v = 1'($urandom_range(0, 1));
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
    end
    cyc(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
